loteria_n: RTL and testbench
============================

LOTERIA_N -- requirements
Module: loteria_n

Interface
REQ-001 Parameter NUM_W, 4, width of each lottery number.
REQ-002 Parameter BET_LEN, 5, numbers per draw and per bet (>=3).
REQ-003 Parameter N_PLAYERS, 2, players served round-robin (>=2).
REQ-004 Parameter SCORE_W, 5, width of each player's score register.
REQ-005 Localparam PL_W = max(1, clog2(N_PLAYERS)).
REQ-006 The block SHALL have one clock; reset is synchronous and active-high. Clock and reset ports are named clock and reset.
REQ-007 clock  in  1  rising-edge clock.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 numero  in  NUM_W  number being loaded or bet.
REQ-010 carrega  in  1  load numero as the next drawn number.
REQ-011 insere  in  1  insert numero as the next bet number.
REQ-012 fim  in  1  end of current player's bet; request evaluation.
REQ-013 fim_jogo  in  1  end of game.
REQ-014 premio  out  2  prize of last evaluated bet.
REQ-015 premio_valido  out  1  one-cycle pulse: premio/jogador newly updated.
REQ-016 jogador  out  PL_W  index of the player last evaluated.
REQ-017 pontos  out  N_PLAYERS*SCORE_W  scores; player i at bits [i*SCORE_W +: SCORE_W].
REQ-018 fim_saida  out  1  game finished.
REQ-019 vencedor  out  PL_W  winner index, valid while fim_saida=1.

Function
REQ-020 FSM states SHALL be CARGA, APOSTA, AVALIA, FIM.
REQ-021 CARGA: each edge with carrega=1 SHALL store numero in draw[lidx], lidx++; after the BET_LEN-th load, go to APOSTA. insere, fim, fim_jogo ignored in CARGA.
REQ-022 APOSTA: each edge with insere=1 and bidx<BET_LEN SHALL set hit[bidx] = (numero==draw[bidx]), bidx++; insere with bidx==BET_LEN ignored; carrega ignored.
REQ-023 APOSTA with fim=1 SHALL go to AVALIA; positions not entered count as misses; insere and fim on the same edge: number recorded first, then AVALIA.
REQ-024 APOSTA with fim_jogo=1 SHALL go to FIM, discarding the open bet without scoring; fim_jogo has priority over fim.
REQ-025 Prize (highest match wins): all BET_LEN hits -> 3; else any run of >=3 adjacent hits -> 2; else total hits >=2 -> 1; else 0.
REQ-026 AVALIA lasts exactly one cycle; on its exit edge premio, jogador, score of current player update and premio_valido=1 for one cycle; then player advances modulo N_PLAYERS, bidx and hit[] clear, state returns to APOSTA.
REQ-027 Latency: fim sampled at edge k -> premio_valido high in the cycle after edge k+1; insere accepted at edge k+1 goes to the next player's bet.
REQ-028 Score increment: prize 3 -> +8, 2 -> +4, 1 -> +1, 0 -> +0; saturating at 2^SCORE_W-1, never wrapping.
REQ-029 premio and jogador SHALL hold their values until the next evaluation.
REQ-030 FIM: fim_saida=1, vencedor = index of maximum score, lowest index on tie; all inputs except reset ignored; state held until reset.

Reset
REQ-031 reset=1 at an edge SHALL, from any state including mid-load or mid-bet, set state CARGA, lidx=bidx=0, draw[] and hit[] to 0, current player 0, pontos=0, premio=0, premio_valido=0, jogador=0, fim_saida=0, vencedor=0.
REQ-032 reset SHALL take priority over every other input on the same edge.

Verification (defaults NUM_W=4, BET_LEN=5, N_PLAYERS=2, SCORE_W=5)
REQ-033 Load 5,3,8,2,0; player 0 bets 5,3,8,2,0, fim -> premio=3, jogador=0, score0=8, premio_valido one cycle, two edges after fim.
REQ-034 Player 1 bets 5,3,8,9,9, fim -> premio=2, jogador=1, score1=4; player 0 bets 5,9,8,9,9 -> premio=1, score0=9.
REQ-035 Player 1 inserts 5 only then fim -> premio=0, score1 unchanged; insere+fim same edge counted correctly.
REQ-036 Player 0 gets four more full matches -> score0 17, 25, 31, 31 (saturated).
REQ-037 fim_jogo mid-bet -> fim_saida=1, vencedor=0, open bet unscored; later insere/fim no effect.
REQ-038 reset during APOSTA after 3 inserts -> all outputs 0, state CARGA; insere before 5 loads ignored.

Source files
------------

// File: rtl/loteria_n.sv
// Lottery draw/bet scorer: loads a BET_LEN-number draw, then evaluates
// round-robin player bets, accumulating saturating scores until end of game.
module loteria_n #(
  parameter int unsigned NUM_W     = 4,
  parameter int unsigned BET_LEN   = 5,
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned SCORE_W   = 5,
  localparam int unsigned PL_W     = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_W-1:0]              numero,
  input  logic                          carrega,
  input  logic                          insere,
  input  logic                          fim,
  input  logic                          fim_jogo,
  output logic [1:0]                    premio,
  output logic                          premio_valido,
  output logic [PL_W-1:0]               jogador,
  output logic [N_PLAYERS*SCORE_W-1:0]  pontos,
  output logic                          fim_saida,
  output logic [PL_W-1:0]               vencedor
);

  localparam int unsigned IDX_W = $clog2(BET_LEN + 1);
  localparam int unsigned SUM_W = SCORE_W + 4;

  typedef enum logic [1:0] {CARGA, APOSTA, AVALIA, FIM} state_t;

  state_t             state, next_state;
  logic [NUM_W-1:0]   draw [BET_LEN];
  logic [BET_LEN-1:0] hit;
  logic [IDX_W-1:0]   lidx, bidx;
  logic [PL_W-1:0]    cur;

  logic [1:0]         prize_c;
  logic [IDX_W-1:0]   n_hits_c;
  logic               run3_c;
  logic [3:0]         inc_c;
  logic [SCORE_W-1:0] cur_score_c;
  logic [SUM_W-1:0]   sum_c;
  logic [SCORE_W-1:0] sat_c;
  logic [SCORE_W-1:0] best_score_c;
  logic [PL_W-1:0]    best_idx_c;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= CARGA;
    else       state <= next_state;
  end

  // Next-state logic; fim_jogo outranks fim while betting
  always_comb begin
    next_state = state;
    case (state)
      CARGA:   if (carrega && lidx == IDX_W'(BET_LEN - 1)) next_state = APOSTA;
      APOSTA:  if (fim_jogo) next_state = FIM;
               else if (fim) next_state = AVALIA;
      AVALIA:  next_state = APOSTA;
      FIM:     next_state = FIM;
      default: next_state = CARGA;
    endcase
  end

  // Prize classification of the current hit vector
  always_comb begin
    n_hits_c = '0;
    run3_c   = 1'b0;
    for (int i = 0; i < int'(BET_LEN); i++)
      n_hits_c = n_hits_c + IDX_W'(hit[i]);
    for (int i = 0; i + 2 < int'(BET_LEN); i++)
      if (hit[i] && hit[i+1] && hit[i+2]) run3_c = 1'b1;
    if (&hit)                         prize_c = 2'd3;
    else if (run3_c)                  prize_c = 2'd2;
    else if (n_hits_c >= IDX_W'(2))   prize_c = 2'd1;
    else                              prize_c = 2'd0;
  end

  // Saturating score update for the current player
  always_comb begin
    case (prize_c)
      2'd3:    inc_c = 4'd8;
      2'd2:    inc_c = 4'd4;
      2'd1:    inc_c = 4'd1;
      default: inc_c = 4'd0;
    endcase
    cur_score_c = pontos[cur*SCORE_W +: SCORE_W];
    sum_c       = SUM_W'(cur_score_c) + SUM_W'(inc_c);
    if (sum_c > SUM_W'({SCORE_W{1'b1}})) sat_c = {SCORE_W{1'b1}};
    else                                 sat_c = sum_c[SCORE_W-1:0];
  end

  // Highest score, lowest index on ties
  always_comb begin
    best_idx_c   = '0;
    best_score_c = pontos[SCORE_W-1:0];
    for (int i = 1; i < int'(N_PLAYERS); i++) begin
      if (pontos[i*SCORE_W +: SCORE_W] > best_score_c) begin
        best_score_c = pontos[i*SCORE_W +: SCORE_W];
        best_idx_c   = PL_W'(i);
      end
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(BET_LEN); i++) draw[i] <= '0;
      hit           <= '0;
      lidx          <= '0;
      bidx          <= '0;
      cur           <= '0;
      pontos        <= '0;
      premio        <= '0;
      premio_valido <= 1'b0;
      jogador       <= '0;
      fim_saida     <= 1'b0;
      vencedor      <= '0;
    end else begin
      premio_valido <= 1'b0;
      case (state)
        CARGA: begin
          if (carrega) begin
            draw[lidx] <= numero;
            lidx       <= lidx + IDX_W'(1);
          end
        end
        APOSTA: begin
          if (insere && bidx < IDX_W'(BET_LEN)) begin
            hit[bidx] <= (numero == draw[bidx]);
            bidx      <= bidx + IDX_W'(1);
          end
          if (fim_jogo) begin
            fim_saida <= 1'b1;
            vencedor  <= best_idx_c;
          end
        end
        AVALIA: begin
          premio                         <= prize_c;
          jogador                        <= cur;
          pontos[cur*SCORE_W +: SCORE_W] <= sat_c;
          premio_valido                  <= 1'b1;
          cur  <= (cur == PL_W'(N_PLAYERS - 1)) ? '0 : cur + PL_W'(1);
          hit  <= '0;
          bidx <= '0;
          // An insert on the exit edge opens the next player's bet
          if (insere) begin
            hit[0] <= (numero == draw[0]);
            bidx   <= IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_loteria_n.sv
// Directed self-checking bench for loteria_n with default parameters.
module tb_loteria_n;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] numero;
  logic       carrega, insere, fim, fim_jogo;
  logic [1:0] premio;
  logic       premio_valido;
  logic [0:0] jogador;
  logic [9:0] pontos;
  logic       fim_saida;
  logic [0:0] vencedor;

  int total = 0;
  int bad   = 0;

  loteria_n dut (
    .clock(clock), .reset(reset), .numero(numero), .carrega(carrega),
    .insere(insere), .fim(fim), .fim_jogo(fim_jogo), .premio(premio),
    .premio_valido(premio_valido), .jogador(jogador), .pontos(pontos),
    .fim_saida(fim_saida), .vencedor(vencedor)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pts(input int s1, input int s0);
    return 32'((s1 << 5) | s0);
  endfunction

  task automatic load(input int n);
    numero = 4'(n); carrega = 1'b1; tick(); carrega = 1'b0;
  endtask

  task automatic bet(input int n);
    numero = 4'(n); insere = 1'b1; tick(); insere = 1'b0;
  endtask

  // fim is taken at the next edge; result shows after the following edge
  task automatic evaluate(input string tag, input int ep, input int ej, input logic [31:0] epts);
    fim = 1'b1; tick(); fim = 1'b0;
    chk({tag, "_early"}, 32'(premio_valido), 0);
    tick();
    chk({tag, "_valid"}, 32'(premio_valido), 1);
    chk({tag, "_premio"}, 32'(premio), 32'(ep));
    chk({tag, "_jogador"}, 32'(jogador), 32'(ej));
    chk({tag, "_pontos"}, 32'(pontos), epts);
    tick();
    chk({tag, "_pulse"}, 32'(premio_valido), 0);
    chk({tag, "_hold"}, 32'(premio), 32'(ep));
  endtask

  initial begin
    reset = 1'b1; numero = '0; carrega = 1'b1; insere = 1'b0; fim = 1'b0; fim_jogo = 1'b0;
    tick(); carrega = 1'b0; tick();
    reset = 1'b0;
    chk("rst_premio", 32'(premio), 0);
    chk("rst_valid", 32'(premio_valido), 0);
    chk("rst_pontos", 32'(pontos), 0);
    chk("rst_fim_saida", 32'(fim_saida), 0);
    chk("rst_vencedor", 32'(vencedor), 0);

    load(5); load(3); load(8); load(2); load(0);

    bet(5); bet(3); bet(8); bet(2); bet(0);
    evaluate("p0_full", 3, 0, pts(0, 8));

    bet(5); bet(3); bet(8); bet(9); bet(9);
    bet(5);
    evaluate("p1_run", 2, 1, pts(4, 8));

    bet(5); bet(9); bet(8); bet(9); bet(9);
    evaluate("p0_two", 1, 0, pts(4, 9));

    numero = 4'd5; insere = 1'b1; fim = 1'b1; tick(); insere = 1'b0; fim = 1'b0;
    tick();
    chk("p1_one_valid", 32'(premio_valido), 1);
    chk("p1_one_premio", 32'(premio), 0);
    chk("p1_one_jogador", 32'(jogador), 1);
    chk("p1_one_pontos", 32'(pontos), pts(4, 9));
    tick();

    bet(5); bet(3); bet(8); bet(2); bet(0);
    evaluate("sat17", 3, 0, pts(4, 17));
    evaluate("p1_empty_a", 0, 1, pts(4, 17));
    bet(5); bet(3); bet(8); bet(2); bet(0);
    evaluate("sat25", 3, 0, pts(4, 25));
    evaluate("p1_empty_b", 0, 1, pts(4, 25));
    bet(5); bet(3); bet(8); bet(2); bet(0);
    evaluate("sat31", 3, 0, pts(4, 31));
    evaluate("p1_empty_c", 0, 1, pts(4, 31));
    bet(5); bet(3); bet(8); bet(2); bet(0);
    evaluate("sat31b", 3, 0, pts(4, 31));

    // Player 1 partial bet abandoned by end of game
    bet(5); bet(3); bet(8);
    fim_jogo = 1'b1; fim = 1'b1; tick(); fim_jogo = 1'b0; fim = 1'b0;
    chk("end_fim_saida", 32'(fim_saida), 1);
    chk("end_vencedor", 32'(vencedor), 0);
    chk("end_pontos", 32'(pontos), pts(4, 31));
    bet(5); bet(3);
    fim = 1'b1; carrega = 1'b1; tick(); fim = 1'b0; carrega = 1'b0;
    tick(); tick();
    chk("end_no_valid", 32'(premio_valido), 0);
    chk("end_pontos_hold", 32'(pontos), pts(4, 31));
    chk("end_jogador_hold", 32'(jogador), 0);
    chk("end_still", 32'(fim_saida), 1);

    reset = 1'b1; tick(); reset = 1'b0;
    load(1); load(1); load(1); load(1); load(1);
    bet(1); bet(1); bet(1);
    reset = 1'b1; insere = 1'b1; fim = 1'b1; tick(); reset = 1'b0; insere = 1'b0; fim = 1'b0;
    chk("rst2_premio", 32'(premio), 0);
    chk("rst2_jogador", 32'(jogador), 0);
    chk("rst2_pontos", 32'(pontos), 0);
    chk("rst2_fim_saida", 32'(fim_saida), 0);
    chk("rst2_valid", 32'(premio_valido), 0);

    // Inserts and fim while loading must be ignored
    bet(7); bet(7);
    fim = 1'b1; tick(); fim = 1'b0; tick();
    chk("carga_no_valid", 32'(premio_valido), 0);
    load(1); load(2); load(3); load(4); load(5);
    bet(1); bet(2); bet(3); bet(4); bet(5);
    evaluate("after_rst", 3, 0, pts(0, 8));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
